// File: rtl/kb_device_responder.sv
// Keyboard/mouse device responder: decodes host serial frames on to_kb and answers
// keyboard/mouse queries on from_kb from two single-entry report buffers.
module kb_device_responder #(
    parameter int BIT_CLKS   = 265,
    parameter int TURNAROUND = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        to_kb,
    output logic        from_kb,
    input  logic        kb_valid,
    input  logic [15:0] kb_data,
    output logic        kb_ready,
    input  logic        ms_valid,
    input  logic [15:0] ms_data,
    output logic        ms_ready,
    output logic [1:0]  led_state,
    output logic        led_update,
    output logic        host_reset,
    output logic        online,
    output logic        frame_error
);

    localparam int TURN_CLKS = BIT_CLKS / 2 + TURNAROUND * BIT_CLKS;
    localparam int CW        = $clog2(TURN_CLKS + 1);

    localparam logic [CW-1:0] HALF_END = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] TURN_END = CW'(TURN_CLKS - 1);

    // Frames are held with bit i = d_i (arrival order).
    localparam logic [7:0]  KB_QUERY    = 8'h10;
    localparam logic [7:0]  MS_QUERY    = 8'h11;
    localparam logic [20:0] RESET_FRAME = 21'h0007EF;
    localparam logic [20:0] LED_FRAME   = 21'h000700;
    localparam logic [20:0] LED_MASK    = 21'h1FCFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_START,
        S_RX_BITS,
        S_TURN,
        S_TX
    } state_t;

    state_t        state_q;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    bit_idx_q;
    logic [20:0]   frame_q;
    logic [19:0]   tx_sh_q;
    logic          query_ms_q;
    logic          from_kb_q;
    logic          kb_full_q, ms_full_q;
    logic [15:0]   kb_buf_q, ms_buf_q;
    logic          online_q;
    logic [1:0]    led_q;
    logic          led_update_q, host_reset_q, frame_error_q;

    logic [20:0]   frame_d;
    logic [20:0]   reply_d;
    logic          sel_full;
    logic [15:0]   sel_buf;

    always_comb begin
        frame_d = frame_q;
        for (int i = 0; i < 21; i++) begin
            if (bit_idx_q == 5'(i)) begin
                frame_d[i] = sync2_q;
            end
        end
        sel_full = query_ms_q ? ms_full_q : kb_full_q;
        sel_buf  = query_ms_q ? ms_buf_q  : kb_buf_q;
        // Line order: start, byte0 LSB-first, M0 M1 M2, byte1 LSB-first, F.
        if (sel_full) begin
            reply_d = {1'b0, sel_buf[15:8], 3'b010, sel_buf[7:0], 1'b0};
        end else begin
            reply_d = {1'b1, 8'h00, 3'b011, 8'h00, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            frame_q       <= '0;
            tx_sh_q       <= '0;
            query_ms_q    <= 1'b0;
            from_kb_q     <= 1'b1;
            kb_full_q     <= 1'b0;
            ms_full_q     <= 1'b0;
            kb_buf_q      <= '0;
            ms_buf_q      <= '0;
            online_q      <= 1'b0;
            led_q         <= 2'b00;
            led_update_q  <= 1'b0;
            host_reset_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync1_q       <= to_kb;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            led_update_q  <= 1'b0;
            host_reset_q  <= 1'b0;
            frame_error_q <= 1'b0;

            if (kb_valid && !kb_full_q) begin
                kb_full_q <= 1'b1;
                kb_buf_q  <= kb_data;
            end
            if (ms_valid && !ms_full_q) begin
                ms_full_q <= 1'b1;
                ms_buf_q  <= ms_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= S_RX_START;
                        cnt_q   <= '0;
                    end
                end

                S_RX_START: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            frame_error_q <= 1'b1;
                            state_q       <= S_IDLE;
                        end else begin
                            state_q   <= S_RX_BITS;
                            bit_idx_q <= '0;
                            frame_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_RX_BITS: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q     <= '0;
                        frame_q   <= frame_d;
                        bit_idx_q <= bit_idx_q + 5'd1;
                        if (bit_idx_q == 5'd7 &&
                            (frame_d[7:0] == KB_QUERY || frame_d[7:0] == MS_QUERY)) begin
                            query_ms_q <= frame_d[0];
                            state_q    <= online_q ? S_TURN : S_IDLE;
                        end else if (bit_idx_q == 5'd20) begin
                            state_q <= S_IDLE;
                            if (frame_d == RESET_FRAME) begin
                                host_reset_q <= 1'b1;
                                online_q     <= 1'b1;
                                kb_full_q    <= 1'b0;
                                ms_full_q    <= 1'b0;
                            end else if ((frame_d & LED_MASK) == LED_FRAME) begin
                                led_q        <= {frame_d[12], frame_d[13]};
                                led_update_q <= 1'b1;
                            end else begin
                                frame_error_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_TURN: begin
                    if (cnt_q == TURN_END) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        from_kb_q <= reply_d[0];
                        tx_sh_q   <= reply_d[20:1];
                        state_q   <= S_TX;
                        // Drain takes priority; the buffer cannot load while full.
                        if (query_ms_q) begin
                            ms_full_q <= 1'b0;
                        end else begin
                            kb_full_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_TX: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 5'd20) begin
                            from_kb_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            from_kb_q <= tx_sh_q[0];
                            tx_sh_q   <= {1'b0, tx_sh_q[19:1]};
                            bit_idx_q <= bit_idx_q + 5'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign from_kb     = from_kb_q;
    assign kb_ready    = ~kb_full_q;
    assign ms_ready    = ~ms_full_q;
    assign led_state   = led_q;
    assign led_update  = led_update_q;
    assign host_reset  = host_reset_q;
    assign online      = online_q;
    assign frame_error = frame_error_q;

endmodule
